// File: rtl/isqrt_scheduler_if.sv
// ============================================================================
// Module  : isqrt_scheduler_if
// Brief   : Request, datapath and result bundle of the shared isqrt scheduler.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface isqrt_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int c_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_x;
    logic [31:0]         isq_x;
    logic [15:0]         isq_y;
    logic                res_valid;
    logic                res_ready;
    logic [c_IDW-1:0]    res_id;
    logic [15:0]         res_y;
    logic                busy;

    modport slave (
        input  req_valid, req_x, isq_y, res_ready,
        output req_ready, isq_x, res_valid, res_id, res_y, busy
    );

    modport master (
        output req_valid, req_x, isq_y, res_ready,
        input  req_ready, isq_x, res_valid, res_id, res_y, busy
    );
endinterface

`default_nettype wire

// File: rtl/isqrt_scheduler.sv
// ============================================================================
// Module  : isqrt_scheduler
// Brief   : Round-robin sharing of a pipelined isqrt datapath with credit-
//           protected in-order result FIFO.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module isqrt_scheduler #(
    parameter int N_REQ      = 4,
    parameter int LATENCY    = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    isqrt_scheduler_if.slave  bus
);
    localparam int c_IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_CW  = $clog2(FIFO_DEPTH + 1);
    localparam int c_AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [c_IDW-1:0]  r_ptr;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   r_fcnt;
    logic [c_AW-1:0]   r_wr;
    logic [c_AW-1:0]   r_rd;
    logic              r_tag_v  [LATENCY];
    logic [c_IDW-1:0]  r_tag_id [LATENCY];
    logic [c_IDW+15:0] r_mem    [FIFO_DEPTH];

    logic              w_any;
    logic              w_hi_found;
    logic [c_IDW-1:0]  w_hi;
    logic [c_IDW-1:0]  w_lo;
    logic [c_IDW-1:0]  w_grant;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_issue;
    logic [N_REQ-1:0]  w_ready;
    logic [31:0]       w_x;

    function automatic logic [c_AW-1:0] f_next(input logic [c_AW-1:0] p);
        return (p == c_AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lowest valid index at or above ptr wins; otherwise wrap to lowest overall.
    always_comb begin
        w_any      = 1'b0;
        w_hi_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_any = 1'b1;
                w_lo  = c_IDW'(i);
                if (i >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi       = c_IDW'(i);
                end
            end
        end
        w_grant = w_hi_found ? w_hi : w_lo;
    end

    assign w_pop   = (r_fcnt != '0) && bus.res_ready;
    assign w_push  = r_tag_v[LATENCY-1];
    assign w_full  = (r_fcnt == c_CW'(FIFO_DEPTH));
    // A pop this cycle hands its credit straight to the issuing requester.
    assign w_issue = !reset && w_any && ((r_cnt < c_CW'(FIFO_DEPTH)) || w_pop);

    always_comb begin
        w_ready = '0;
        w_x     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_issue && (c_IDW'(i) == w_grant)) begin
                w_ready[i] = 1'b1;
                w_x        = bus.req_x[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_fcnt <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tag_v[i]  <= 1'b0;
                r_tag_id[i] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_ptr <= (w_grant == c_IDW'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
            end
            if (w_issue && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_issue && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_tag_v[0]  <= w_issue;
            r_tag_id[0] <= w_grant;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
            if (w_push) begin
                r_wr <= f_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_next(r_rd);
            end
            if (w_push && !w_pop) begin
                r_fcnt <= r_fcnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fcnt <= r_fcnt - 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr] <= {r_tag_id[LATENCY-1], bus.isq_y};
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.isq_x     = w_x;
    assign bus.res_valid = (r_fcnt != '0);
    assign bus.res_id    = r_mem[r_rd][c_IDW+15:16];
    assign bus.res_y     = r_mem[r_rd][15:0];
    assign bus.busy      = (r_cnt != '0);

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(w_push && w_full && !w_pop));

endmodule

`default_nettype wire

// File: tb/tb_isqrt_scheduler.sv
// ============================================================================
// Module  : tb_isqrt_scheduler
// Brief   : Directed and random stimulus against a queue-based scheduler model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_isqrt_scheduler;
    localparam int N_REQ      = 4;
    localparam int LATENCY    = 16;
    localparam int FIFO_DEPTH = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    isqrt_scheduler_if #(.N_REQ(N_REQ)) bus ();

    isqrt_scheduler #(
        .N_REQ(N_REQ),
        .LATENCY(LATENCY),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [15:0] ref_isqrt(input logic [31:0] x);
        longint lo = 0;
        longint hi = 65535;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
        end
        return 16'(lo);
    endfunction

    // Ideal pipelined datapath surrounding the scheduler.
    logic [15:0] dp [LATENCY];
    always @(posedge clock) begin
        dp[0] <= ref_isqrt(bus.isq_x);
        for (int i = 1; i < LATENCY; i++) dp[i] <= dp[i-1];
    end
    assign bus.isq_y = dp[LATENCY-1];

    typedef struct {
        int          id;
        logic [15:0] y;
        int          avail;
    } exp_t;

    exp_t q[$];
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_issue = 0;
    bit   checking = 0;

    logic [N_REQ-1:0] s_ready;
    int               s_grant;
    bit               s_pop;
    logic             s_rv;
    logic             s_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_x(input int i, input logic [31:0] v);
        bus.req_x[i*32 +: 32] = v;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: begin r = 32'($urandom_range(0, 65535)); return r * r; end
            default: return 32'($urandom);
        endcase
    endfunction

    // One clock cycle: check at negedge against the model, advance model at posedge.
    task automatic cycle();
        bit               e_valid;
        bit               e_pop;
        bit               e_issue;
        int               g;
        logic [N_REQ-1:0] e_ready;
        logic [31:0]      e_x;
        @(negedge clock);
        e_valid = (q.size() > 0) && (q[0].avail <= cyc);
        e_pop   = e_valid && bus.res_ready;
        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int i = (m_ptr + k) % N_REQ;
            if (g < 0 && bus.req_valid[i]) g = i;
        end
        e_issue = !reset && (g >= 0) && (m_cnt < FIFO_DEPTH || e_pop);
        e_ready = '0;
        e_x     = '0;
        if (e_issue) begin
            e_ready[g] = 1'b1;
            e_x        = bus.req_x[g*32 +: 32];
        end
        if (checking) begin
            chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
            chk("isq_x", bus.isq_x, e_x);
            chk("res_valid", 32'(bus.res_valid), 32'(e_valid));
            chk("busy", 32'(bus.busy), 32'(m_cnt != 0));
            if (e_valid) begin
                chk("res_id", 32'(bus.res_id), 32'(q[0].id));
                chk("res_y", 32'(bus.res_y), 32'(q[0].y));
            end
        end
        s_ready = bus.req_ready;
        s_pop   = e_pop;
        s_rv    = bus.res_valid;
        s_busy  = bus.busy;
        s_grant = -1;
        for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i] === 1'b1) s_grant = i;
        if (s_grant >= 0) n_issue++;
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_cnt = 0;
            m_ptr = 0;
        end else begin
            if (e_pop) begin
                void'(q.pop_front());
                m_cnt--;
            end
            if (e_issue) begin
                q.push_back('{g, ref_isqrt(e_x), cyc + LATENCY + 1});
                m_cnt++;
                m_ptr = (g + 1) % N_REQ;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int first;
        int prev;
        int pops;

        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.res_ready = 1'b0;

        // Reset state
        cycle();
        cycle();
        checking = 1;
        cycle();
        chk("reset_req_ready", 32'(s_ready), 32'h0);
        chk("reset_res_valid", 32'(s_rv), 32'h0);
        chk("reset_busy", 32'(s_busy), 32'h0);
        reset = 1'b0;
        idle(2);

        // Single operation: 144 -> 12 after LATENCY+1 cycles
        set_x(0, 32'd144);
        bus.req_valid = 4'b0001;
        bus.res_ready = 1'b1;
        t0 = cyc;
        cycle();
        chk("single_grant", 32'(s_ready), 32'h1);
        bus.req_valid = '0;
        first = -1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (s_rv === 1'b1) begin
                first = cyc - 1;
                break;
            end
        end
        chk("single_latency", 32'(first - t0), 32'(LATENCY + 1));
        cycle();
        chk("single_busy_after", 32'(s_busy), 32'h0);
        idle(3);

        // Full load with fixed operands
        set_x(0, 32'd0);
        set_x(1, 32'd1);
        set_x(2, 32'hFFFF_FFFF);
        set_x(3, 32'd15);
        bus.req_valid = 4'b1111;
        prev = -1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (prev >= 0) chk("full_load_grant", 32'(s_grant), 32'((prev + 1) % N_REQ));
            prev = s_grant;
        end
        idle(25);

        // Random traffic with random backpressure
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N_REQ; i++) set_x(i, rand_operand());
            bus.req_valid = 4'($urandom);
            bus.res_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        idle(60);

        // Backpressure: credits cap issues at FIFO_DEPTH
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0100;
        n_issue = 0;
        for (int k = 0; k < 60; k++) begin
            set_x(2, rand_operand());
            cycle();
        end
        chk("bp_issue_count", 32'(n_issue), 32'(FIFO_DEPTH));
        chk("bp_ready_stalled", 32'(s_ready), 32'h0);
        chk("bp_busy", 32'(s_busy), 32'h1);

        // Full and simultaneous: pop frees a credit for a same-cycle issue
        bus.res_ready = 1'b1;
        n_issue = 0;
        pops = 0;
        for (int k = 0; k < 32; k++) begin
            set_x(2, rand_operand());
            cycle();
            if (s_rv === 1'b1) pops++;
            if (k == 0) begin
                chk("bp_first_pop_issue", 32'(s_ready), 32'h4);
                chk("bp_first_pop", 32'(s_pop), 32'h1);
            end
        end
        chk("bp_pop_count", 32'(pops), 32'(FIFO_DEPTH));
        chk("bp_reissue_count", 32'(n_issue), 32'(FIFO_DEPTH));
        idle(60);

        // Fairness between requesters 1 and 3
        set_x(1, 32'd99);
        set_x(3, 32'd1_000_000);
        bus.req_valid = 4'b1010;
        prev = -1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (prev >= 0) chk("fair_grant", 32'(s_grant), 32'((prev == 1) ? 3 : 1));
            prev = s_grant;
        end
        idle(25);

        // Reset mid-flight
        bus.req_valid = 4'b0001;
        n_issue = 0;
        for (int k = 0; k < 5; k++) begin
            set_x(0, rand_operand());
            cycle();
        end
        chk("mid_issue_count", 32'(n_issue), 32'd5);
        bus.req_valid = '0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("mid_res_valid_low", 32'(s_rv), 32'h0);
            if (k == 0) chk("mid_busy_cleared", 32'(s_busy), 32'h0);
        end
        set_x(0, 32'd49);
        set_x(3, 32'd81);
        bus.req_valid = 4'b1001;
        cycle();
        chk("mid_ptr_reset_grant", 32'(s_grant), 32'h0);
        idle(25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
